// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared width, ALU opcodes and arbiter FSM encoding.  Rev 1.0
// ============================================================================
package alu_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

  function automatic logic is_logic_op(input logic [2:0] op);
    return (op == ALU_AND) || (op == ALU_OR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// alu : combinational AND/OR/ADD/SUB/SLT with zero, overflow and carry flags.  Rev 1.0
// ============================================================================
module alu #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [2:0]            op_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  overflow_o,
  output logic                  carryout_o
);
  import alu_pkg::*;

  logic                  sub;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   sum;

  always_comb begin
    sub   = (op_i == ALU_SUB) || (op_i == ALU_SLT);
    b_eff = sub ? ~b_i : b_i;
    sum   = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub};
    // Signed overflow: operands agree in sign but the sum does not.
    overflow_o = (a_i[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                 (sum[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
    carryout_o = sum[DATA_WIDTH];
    case (op_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: result_o = sum[DATA_WIDTH-1:0];
      ALU_SUB: result_o = sum[DATA_WIDTH-1:0];
      ALU_SLT: result_o = {{(DATA_WIDTH-1){1'b0}}, sum[DATA_WIDTH-1] ^ overflow_o};
      default: result_o = '0;
    endcase
    zero_o = (result_o == '0);
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin sharing of one alu between two requesters.  Rev 1.0
// ============================================================================
module alu_arbiter #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [1:0][DATA_WIDTH-1:0] req_a_i,
  input  logic [1:0][DATA_WIDTH-1:0] req_b_i,
  input  logic [1:0][2:0]            req_op_i,
  output logic [1:0]                 resp_valid_o,
  input  logic [1:0]                 resp_ready_i,
  output logic [DATA_WIDTH-1:0]      resp_result_o,
  output logic                       resp_zero_o,
  output logic                       resp_overflow_o,
  output logic                       resp_carryout_o,
  output logic                       resp_err_o
);
  import alu_pkg::*;

  state_e                state_q;
  logic                  prio_q;
  logic                  owner_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [2:0]            op_q;
  logic [1:0]            resp_valid_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic                  overflow_q;
  logic                  carryout_q;
  logic                  err_q;

  logic                  grant;
  logic                  accept;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  alu_overflow;
  logic                  alu_carryout;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a_i        (a_q),
    .b_i        (b_q),
    .op_i       (op_q),
    .result_o   (alu_result),
    .zero_o     (alu_zero),
    .overflow_o (alu_overflow),
    .carryout_o (alu_carryout)
  );

  always_comb begin
    grant       = (req_valid_i == 2'b11) ? prio_q : req_valid_i[1];
    req_ready_o = 2'b00;
    if ((state_q == ST_IDLE) && !rst && (req_valid_i != 2'b00)) begin
      req_ready_o[grant] = 1'b1;
    end
    accept = (req_ready_o != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= ALU_AND;
      resp_valid_q <= 2'b00;
      result_q     <= '0;
      zero_q       <= 1'b0;
      overflow_q   <= 1'b0;
      carryout_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= req_a_i[grant];
            b_q     <= req_b_i[grant];
            op_q    <= req_op_i[grant];
            owner_q <= grant;
            prio_q  <= ~grant;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_q      <= ST_RESP;
          resp_valid_q <= owner_q ? 2'b10 : 2'b01;
          if (is_legal_op(op_q)) begin
            result_q   <= alu_result;
            zero_q     <= alu_zero;
            overflow_q <= is_logic_op(op_q) ? 1'b0 : alu_overflow;
            carryout_q <= is_logic_op(op_q) ? 1'b0 : alu_carryout;
            err_q      <= 1'b0;
          end else begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            carryout_q <= 1'b0;
            err_q      <= 1'b1;
          end
        end
        ST_RESP: begin
          // Only the owner's bit of resp_valid_q is set, so the non-owner's ready is masked.
          if ((resp_valid_q & resp_ready_i) != 2'b00) begin
            resp_valid_q <= 2'b00;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid_o    = resp_valid_q;
  assign resp_result_o   = result_q;
  assign resp_zero_o     = zero_q;
  assign resp_overflow_o = overflow_q;
  assign resp_carryout_o = carryout_q;
  assign resp_err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : directed vector table plus multi-cycle arbitration sequences.  Rev 1.0
// ============================================================================
module tb_alu_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][2:0]  req_op;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [31:0]      resp_result;
  logic             resp_zero;
  logic             resp_overflow;
  logic             resp_carryout;
  logic             resp_err;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_a_i         (req_a),
    .req_b_i         (req_b),
    .req_op_i        (req_op),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_result_o   (resp_result),
    .resp_zero_o     (resp_zero),
    .resp_overflow_o (resp_overflow),
    .resp_carryout_o (resp_carryout),
    .resp_err_o      (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic [3:0]  zvce;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, resp_zero, resp_overflow, resp_carryout, resp_err};
  endfunction

  initial begin
    // {id, a, b, op, result, {zero, overflow, carryout, err}}
    vecs[0]  = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 4'b0100};
    vecs[1]  = '{1'b0, 32'h00000005, 32'h00000005, 3'b110, 32'h00000000, 4'b1010};
    vecs[2]  = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 4'b0010};
    vecs[3]  = '{1'b1, 32'hF0F00000, 32'h00000F0F, 3'b001, 32'hF0F00F0F, 4'b0000};
    vecs[4]  = '{1'b0, 32'h12345678, 32'h9ABCDEF0, 3'b011, 32'h00000000, 4'b1001};
    vecs[5]  = '{1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 3'b000, 32'h0F000F00, 4'b0000};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 4'b1010};
    vecs[7]  = '{1'b1, 32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 4'b0110};
    vecs[8]  = '{1'b0, 32'h00000001, 32'h00000002, 3'b111, 32'h00000001, 4'b0000};
    vecs[9]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101, 32'h00000000, 4'b1001};
    vecs[10] = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 4'b0110};

    rst        = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    step();
    step();
    chk("reset_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("reset_result", resp_result, 32'd0);
    chk("reset_flags", flags(), 32'd0);
    req_valid = 2'b01;
    #1;
    chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    #1;

    // Single-requester vectors
    for (int i = 0; i < 11; i++) begin
      req_a[vecs[i].id]     = vecs[i].a;
      req_b[vecs[i].id]     = vecs[i].b;
      req_op[vecs[i].id]    = vecs[i].op;
      req_valid[vecs[i].id] = 1'b1;
      #1;
      chk($sformatf("v%0d_req_ready", i), {30'd0, req_ready}, vecs[i].id ? 32'd2 : 32'd1);
      step();
      req_valid = 2'b00;
      chk($sformatf("v%0d_exec_idle", i), {30'd0, resp_valid}, 32'd0);
      step();
      chk($sformatf("v%0d_resp_valid", i), {30'd0, resp_valid}, vecs[i].id ? 32'd2 : 32'd1);
      chk($sformatf("v%0d_result", i), resp_result, vecs[i].res);
      chk($sformatf("v%0d_flags", i), flags(), {28'd0, vecs[i].zvce});
      resp_ready[vecs[i].id] = 1'b1;
      step();
      resp_ready = 2'b00;
      chk($sformatf("v%0d_consumed", i), {30'd0, resp_valid}, 32'd0);
    end

    // Fresh reset so the alternation starts from prio = 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_a[0] = 32'd5;         req_b[0] = 32'd5; req_op[0] = 3'b110;
    req_a[1] = 32'hFFFFFFFF;  req_b[1] = 32'd1; req_op[1] = 3'b111;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("alt%0d_grant", k), {30'd0, req_ready}, (k % 2) ? 32'd2 : 32'd1);
      step();
      chk($sformatf("alt%0d_exec", k), {30'd0, resp_valid}, 32'd0);
      step();
      chk($sformatf("alt%0d_resp_valid", k), {30'd0, resp_valid}, (k % 2) ? 32'd2 : 32'd1);
      chk($sformatf("alt%0d_result", k), resp_result, (k % 2) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_flags", k), flags(), (k % 2) ? 32'h0000_0002 : 32'h0000_000A);
      step();
    end

    // prio now points at requester 1; hold its response with resp_ready[1] low
    req_a[1] = 32'hF0F00000; req_b[1] = 32'h00000F0F; req_op[1] = 3'b001;
    resp_ready = 2'b01;
    #1;
    chk("hold_grant", {30'd0, req_ready}, 32'd2);
    step();
    req_valid[1] = 1'b0;
    step();
    chk("hold_resp_valid", {30'd0, resp_valid}, 32'd2);
    chk("hold_result", resp_result, 32'hF0F00F0F);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("hold%0d_resp_valid", k), {30'd0, resp_valid}, 32'd2);
      chk($sformatf("hold%0d_result", k), resp_result, 32'hF0F00F0F);
      chk($sformatf("hold%0d_req_ready", k), {30'd0, req_ready}, 32'd0);
    end
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b00;
    chk("resume_grant", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    step();
    chk("resume_resp_valid", {30'd0, resp_valid}, 32'd1);
    chk("resume_result", resp_result, 32'd0);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;

    // Reset during EXEC with prio pointing at requester 1
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    chk("rst_exec_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_exec_req_ready", {30'd0, req_ready}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_exec_grant", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    step();
    chk("pre_rst_resp_valid", {30'd0, resp_valid}, 32'd1);

    // Reset during RESP
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_resp_flags", flags(), 32'd0);
    step();
    rst = 1'b0;
    resp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst%0d_resp_valid", k), {30'd0, resp_valid}, 32'd0);
    end
    req_valid = 2'b11;
    #1;
    chk("post_rst_grant", {30'd0, req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance (AND/OR/ADD/SUB/SLT, 32-bit) between two requesters, e.g. the execute stage and a multi-cycle helper unit. Each requester has a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, latches operands, registers the ALU result and flags, and holds the response until the owning requester accepts it. One operation is in flight at a time.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid[i]`  in  1  requester i (i = 0, 1) presents an operation.
- `req_ready[i]`  out  1  arbiter accepts requester i this cycle.
- `req_a[i]`, `req_b[i]`  in  DATA_WIDTH  operands of requester i.
- `req_op[i]`  in  3  ALUop of requester i: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `resp_valid[i]`  out  1  response for requester i is available.
- `resp_ready[i]`  in  1  requester i accepts the response.
- `resp_result`  out  DATA_WIDTH  registered ALU result.
- `resp_zero`, `resp_overflow`, `resp_carryout`  out  1  registered ALU flags.
- `resp_err`  out  1  the op was illegal (011, 100 or 101).

## Operation
- FSM states:
  - IDLE: ready for a new request.
  - EXEC: operands latched, ALU evaluating.
  - RESP: response held for the owner.
- Transitions:
  - IDLE → EXEC on `req_valid[i] && req_ready[i]`.
  - EXEC → RESP unconditionally.
  - RESP → IDLE on `resp_valid[owner] && resp_ready[owner]`.
- Grant, combinational in IDLE only:
  - Only one requester valid: that one gets `req_ready`.
  - Both valid: the one named by priority pointer `prio` wins.
  - At most one `req_ready` is ever high. Both are 0 outside IDLE.
- On accept:
  - Latch a, b, op and owner index.
  - Set `prio` to the non-winner. `prio` changes only on an accept.
- EXEC: the latched operands drive the `alu`. Result and flags are registered at the end of EXEC.
- Illegal op:
  - The `alu` is bypassed.
  - Result 0, `resp_zero`=1, `resp_overflow`=0, `resp_carryout`=0, `resp_err`=1.
- Legal op: `resp_err`=0.
- Flag meanings (the registered output carries what the `alu` produces):
  - CarryOut is the adder carry for ADD and the A+~B+1 carry for SUB/SLT.
  - Overflow is signed overflow.
  - SLT result is `{0…, sign ^ overflow}`.
  - For AND/OR, registered `resp_overflow` and `resp_carryout` are forced to 0.
- RESP:
  - Only `resp_valid[owner]` = 1.
  - `resp_*` data is stable until the handshake.
  - `resp_ready` of the non-owner is ignored.
- The request channel obeys the handshake rules: once asserted, `req_valid` and its payload stay stable until accepted. The arbiter does not check this.

## Timing
- Reset values:
  - state IDLE, `prio`=0.
  - `req_ready`=0, `resp_valid`=0.
  - `resp_result`=0, all flags 0.
  - `req_ready` becomes combinationally valid in IDLE once `rst` deasserts.
- Latency: accept on edge N → `resp_valid` high during cycle N+2.
- Response consumed in the same cycle → next accept is possible at edge N+3.
- Throughput: at most one operation per 3 cycles.
- `resp_ready` held low: stays in RESP indefinitely with no new accepts, and the other requester waits.
- `resp_ready` high before `resp_valid`: no effect until RESP.
- Both requesters continuously valid: grants alternate 0,1,0,1…, so neither starves.
- Reset mid-operation (EXEC or RESP): the transaction is dropped and no response is issued. All outputs reach their reset values asynchronously, and the priority pointer returns to 0.
- No combinational path from `resp_ready` to `resp_*` data. `req_ready` depends combinationally on `req_valid` and state only.

## Structure
- Shared package `alu_pkg`:
  - `DATA_WIDTH` default.
  - ALUop constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`.
  - FSM state encoding IDLE/EXEC/RESP.
- One sub-module: the existing `alu`, instantiated once and driven only by the latched operand registers.
- Arbiter, FSM and response registers live in `alu_arbiter`.

## Test plan
- After reset release, only requester 0 valid with a=0x7FFFFFFF, b=1, op=ADD → `resp_valid[0]` two cycles after accept. Result 0x80000000, overflow=1, carryout=0, zero=0.
- Both valid every cycle with `resp_ready` tied high: requester 0 SUB 5−5, requester 1 SLT a=0xFFFFFFFF, b=1.
  - Grants alternate 0,1,0.
  - Requester 0 gets result 0 with zero=1, carryout=1.
  - Requester 1 gets result 1.
- Requester 1 sends OR 0xF0F0_0000 | 0x0000_0F0F with `resp_ready[1]` low for 5 cycles.
  - Response holds 0xF0F00F0F stable.
  - `req_ready[0]` stays 0 throughout.
  - Accepts resume one cycle after the handshake.
- Illegal op 011 from requester 0 → result 0, zero=1, err=1, overflow=0, carryout=0.
- Assert `rst` during EXEC and then during RESP → no `resp_valid` afterward, all outputs 0, and the next grant with both requesters valid goes to requester 0.
- `resp_ready[0]` high while requester 1 owns the response → requester 1's response is not consumed and the FSM stays in RESP.
